// File: rtl/hex_display_slave.sv
// -----------------------------------------------------------------------------
// hex_display_slave
//
// Avalon-MM slave that owns the six DE1-SoC seven-segment displays.
// A master writes a 24-bit value (six hex nibbles), enable/blank/blink masks
// and a blink half-period divider. Each nibble is decoded to active-low
// segments, with per-digit blanking and blinking. An ADD register allows
// in-place accumulation into VALUE.
//
// Register map (word addresses):
//   0 VALUE      [23:0] R/W
//   1 CTRL       [0] enable, [6:1] blank mask, [12:7] blink mask
//   2 BLINK_DIV  [DIV_W-1:0] R/W; write reloads counter and clears phase
//   3 STATUS     [0] blink phase, read-only
//   4 ADD        write-only: VALUE <= VALUE + writedata[23:0] (mod 2^24)
//   others       read 0, writes ignored
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   address      word address
//   read/write   Avalon strobes
//   writedata    write data
//   readdata     read data, valid in the cycle waitrequest drops after a read
//   waitrequest  high for the first cycle of a read only; writes never stall
//   hex0..hex5   active-low segments {g,f,e,d,c,b,a}; hex0 shows nibble 0
// -----------------------------------------------------------------------------
module hex_display_slave #(
  parameter int unsigned BLINK_RESET = 25_000_000,
  parameter int unsigned DIV_W       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam logic [2:0] ADDR_VALUE  = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_DIV    = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_ADD    = 3'd4;

  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(BLINK_RESET);

  typedef enum logic {
    IDLE,
    RD
  } state_t;

  state_t            state;
  logic [23:0]       value;
  logic [12:0]       ctrl;
  logic [DIV_W-1:0]  blink_div;
  logic [DIV_W-1:0]  blink_cnt;
  logic              phase;
  logic [6:0]        hex_q [6];
  logic [31:0]       rd_mux;
  logic              wr_en;

  // Writes are only accepted while no read is in flight.
  assign wr_en = write && (state == IDLE);

  // -------------------------------------------------------------------------
  // Nibble to active-low segment decode, bit order {g,f,e,d,c,b,a}
  // -------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // -------------------------------------------------------------------------
  // Read mux (sampled into readdata when a read is accepted)
  // -------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_VALUE:  rd_mux = {8'h00, value};
      ADDR_CTRL:   rd_mux = {19'h0, ctrl};
      ADDR_DIV:    rd_mux = 32'(blink_div);
      ADDR_STATUS: rd_mux = {31'h0, phase};
      default:     rd_mux = '0;
    endcase
  end

  // waitrequest is combinational so the master stalls in the same cycle it
  // raises read; gating with rst_n drops it immediately on reset.
  always_comb begin
    waitrequest = rst_n && (state == IDLE) && read && !write;
  end

  // -------------------------------------------------------------------------
  // Read FSM: IDLE captures the register, RD presents it for one cycle
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      readdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read && !write) begin
            state    <= RD;
            readdata <= rd_mux;
          end
        end
        RD: begin
          state    <= IDLE;
          readdata <= '0;
        end
        default: begin
          state    <= IDLE;
          readdata <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // VALUE / CTRL registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      ctrl  <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_VALUE: value <= writedata[23:0];
        ADDR_CTRL:  ctrl  <= writedata[12:0];
        ADDR_ADD:   value <= value + writedata[23:0];  // 24-bit wrap, carry dropped
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Blink divider: phase toggles every BLINK_DIV+1 cycles; a zero divider
  // freezes the counter and forces the phase low.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_div <= DIV_RESET;
      blink_cnt <= DIV_RESET;
      phase     <= 1'b0;
    end else if (wr_en && (address == ADDR_DIV)) begin
      blink_div <= DIV_W'(writedata);
      blink_cnt <= DIV_W'(writedata);
      phase     <= 1'b0;
    end else if (blink_div == '0) begin
      phase <= 1'b0;
    end else if (blink_cnt == '0) begin
      blink_cnt <= blink_div;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt - 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Registered digit outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 6; i++) begin
        hex_q[i] <= '1;
      end
    end else begin
      for (int unsigned i = 0; i < 6; i++) begin
        if (!ctrl[0] || ctrl[1 + i] || (ctrl[7 + i] && phase)) begin
          hex_q[i] <= '1;
        end else begin
          hex_q[i] <= seg_decode(value[4 * i +: 4]);
        end
      end
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule

// File: tb/tb_hex_display_slave.sv
// -----------------------------------------------------------------------------
// tb_hex_display_slave
//
// Directed plus randomized stimulus for hex_display_slave. A behavioural
// model tracks the register file and derives the blink phase arithmetically
// from the number of cycles since the divider was last loaded.
// -----------------------------------------------------------------------------
module tb_hex_display_slave;

  localparam int unsigned BR = 40;

  logic        clk;
  logic        rst_n;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [6:0]  hexv [6];

  int compared   = 0;
  int mismatched = 0;
  logic rd_busy  = 1'b0;

  hex_display_slave #(
    .BLINK_RESET(BR),
    .DIV_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .waitrequest(waitrequest),
    .hex0(hex0),
    .hex1(hex1),
    .hex2(hex2),
    .hex3(hex3),
    .hex4(hex4),
    .hex5(hex5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    hexv[0] = hex0;
    hexv[1] = hex1;
    hexv[2] = hex2;
    hexv[3] = hex3;
    hexv[4] = hex4;
    hexv[5] = hex5;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                      7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                      7'h46, 7'h21, 7'h06, 7'h0E};

  logic [23:0] m_value;
  logic [12:0] m_ctrl;
  logic [31:0] m_div;
  longint      m_k;        // cycles since divider was loaded
  logic [6:0]  exp_hex [6];

  function automatic logic m_phase();
    if (m_div == 0) return 1'b0;
    return ((m_k / (longint'(m_div) + 1)) % 2) == 1;
  endfunction

  function automatic logic [6:0] ref_digit(input int i);
    logic [3:0] nib;
    bit enabled, blanked, blinked_off;
    enabled     = (m_ctrl & 13'h1) != 0;
    blanked     = ((m_ctrl >> (1 + i)) & 13'h1) != 0;
    blinked_off = (((m_ctrl >> (7 + i)) & 13'h1) != 0) && m_phase();
    nib         = 4'((m_value >> (4 * i)) % 16);
    if (!enabled || blanked || blinked_off) return 7'h7F;
    return SEG[nib];
  endfunction

  function automatic logic [31:0] m_readback(input logic [2:0] a);
    case (a)
      3'd0:    return {8'h00, m_value};
      3'd1:    return {19'h0, m_ctrl};
      3'd2:    return m_div;
      3'd3:    return {31'h0, m_phase()};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_value = '0;
      m_ctrl  = '0;
      m_div   = BR;
      m_k     = 0;
      for (int i = 0; i < 6; i++) exp_hex[i] = 7'h7F;
    end else begin
      for (int i = 0; i < 6; i++) exp_hex[i] = ref_digit(i);
      if (write && address == 3'd2) begin
        m_div = writedata;
        m_k   = 0;
      end else begin
        m_k = m_k + 1;
      end
      if (write) begin
        case (address)
          3'd0: m_value = writedata[23:0];
          3'd1: m_ctrl  = writedata[12:0];
          3'd4: m_value = 24'((longint'(m_value) + longint'(writedata[23:0])) % (longint'(1) << 24));
          default: ;
        endcase
      end
    end
  end

  // The master must never present a write while a read is outstanding.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(write && rd_busy)) else begin
        mismatched++;
        $error("FAIL write_during_rd observed=1 expected=0");
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_hex();
    for (int i = 0; i < 6; i++)
      chk($sformatf("hex%0d", i), {25'h0, hexv[i]}, {25'h0, exp_hex[i]});
  endtask

  // Called at a negedge; returns at a later negedge.
  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    read      = 1'b0;
    #1 chk("wr_waitreq", {31'h0, waitrequest}, 32'h0);
    @(posedge clk);
    #1 write = 1'b0;
    @(negedge clk);
    check_hex();
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d);
    logic [31:0] exp;
    address = a;
    read    = 1'b1;
    write   = 1'b0;
    rd_busy = 1'b1;
    exp     = m_readback(a);
    #1 chk("rd_waitreq_hi", {31'h0, waitrequest}, 32'h1);
    @(negedge clk);
    chk("rd_waitreq_lo", {31'h0, waitrequest}, 32'h0);
    chk($sformatf("rd_data_a%0d", a), readdata, exp);
    d = readdata;
    @(posedge clk);
    #1 read = 1'b0;
    rd_busy = 1'b0;
    @(negedge clk);
    check_hex();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_hex();
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] d;
    rst_n     = 1'b0;
    read      = 1'b0;
    write     = 1'b0;
    address   = '0;
    writedata = '0;

    // 1. Reset state
    @(negedge clk);
    for (int i = 0; i < 6; i++) chk($sformatf("rst_hex%0d", i), {25'h0, hexv[i]}, 32'h7F);
    chk("rst_waitreq", {31'h0, waitrequest}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    do_read(3'd2, d);
    chk("blink_div_reset", d, BR);

    // 2. Basic decode
    do_write(3'd0, 32'h0000A5C3);
    do_write(3'd1, 32'h1);
    idle(1);
    chk("dec_hex0", {25'h0, hex0}, 32'h30);
    chk("dec_hex1", {25'h0, hex1}, 32'h46);
    chk("dec_hex2", {25'h0, hex2}, 32'h12);
    chk("dec_hex3", {25'h0, hex3}, 32'h08);
    chk("dec_hex4", {25'h0, hex4}, 32'h40);
    chk("dec_hex5", {25'h0, hex5}, 32'h40);
    do_read(3'd0, d);
    chk("value_rb", d, 32'h00A5C3);

    // 3. Blank digit 2, blink digit 1 with an 8-cycle period
    do_write(3'd2, 32'd3);
    do_write(3'd1, 32'h1 | (32'h1 << 3) | (32'h1 << 8));
    for (int t = 0; t < 24; t++) begin
      idle(1);
      chk("blank_hex2", {25'h0, hex2}, 32'h7F);
    end
    for (int t = 0; t < 4; t++) begin
      do_read(3'd3, d);
      idle(t + 1);
    end

    // 4. ADD wraps; write-only and unmapped addresses read 0
    do_write(3'd0, 32'h00FFFFFE);
    do_write(3'd4, 32'd3);
    do_read(3'd0, d);
    chk("add_wrap", d, 32'h000001);
    do_read(3'd4, d);
    chk("add_read0", d, 32'h0);
    do_read(3'd7, d);
    chk("unmapped_read0", d, 32'h0);
    do_write(3'd3, 32'hFFFFFFFF);
    do_write(3'd6, 32'hFFFFFFFF);

    // 5. Simultaneous read and write: write lands, no read transaction
    address   = 3'd0;
    writedata = 32'h00123456;
    read      = 1'b1;
    write     = 1'b1;
    #1 chk("rw_waitreq", {31'h0, waitrequest}, 32'h0);
    @(posedge clk);
    #1 read = 1'b0;
    write = 1'b0;
    @(negedge clk);
    check_hex();
    do_read(3'd0, d);
    chk("rw_value", d, 32'h00123456);

    // 6. Zero divider holds phase at 0
    do_write(3'd2, 32'd0);
    do_write(3'd1, 32'h1 | (32'h3F << 7));
    repeat (10) begin
      idle(7);
      do_read(3'd3, d);
      chk("status_frozen", d, 32'h0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      logic [2:0]  a;
      op = $urandom_range(0, 3);
      a  = 3'($urandom_range(0, 7));
      case (op)
        0: begin
          if (a == 3'd2) do_write(a, 32'($urandom_range(0, 6)));
          else           do_write(a, $urandom);
        end
        1: do_read(a, d);
        default: idle(int'($urandom_range(1, 5)));
      endcase
    end

    // Reset during the RD cycle of a read
    do_write(3'd0, 32'h00ABCDEF);
    address = 3'd0;
    read    = 1'b1;
    rd_busy = 1'b1;
    #1 chk("mid_rd_waitreq_hi", {31'h0, waitrequest}, 32'h1);
    @(negedge clk);
    chk("mid_rd_waitreq_lo", {31'h0, waitrequest}, 32'h0);
    rst_n = 1'b0;
    #1 chk("rst_in_rd_waitreq", {31'h0, waitrequest}, 32'h0);
    read    = 1'b0;
    rd_busy = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) chk($sformatf("rst2_hex%0d", i), {25'h0, hexv[i]}, 32'h7F);
    rst_n = 1'b1;
    idle(1);
    do_read(3'd0, d);
    chk("rst2_value", d, 32'h0);
    do_read(3'd1, d);
    chk("rst2_ctrl", d, 32'h0);
    do_read(3'd2, d);
    chk("rst2_div", d, BR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
